// File: rtl/uart_pkg.sv
// Shared types and constants for the oversampling UART receiver.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } rx_state_e;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  localparam int OVERSAMPLE = 16;

  localparam logic [3:0] SAMPLE_EARLY = 4'd7;
  localparam logic [3:0] SAMPLE_MID   = 4'd8;
  localparam logic [3:0] SAMPLE_LATE  = 4'd9;
  localparam logic [3:0] OS_LAST      = 4'(OVERSAMPLE - 1);

endpackage

// File: rtl/uart_rx_fifo.sv
// Register-based synchronous FIFO with show-ahead head, full/empty and level.
module uart_rx_fifo #(
  parameter int width = 10,
  parameter int depth = 8,
  parameter int aw    = $clog2(depth)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [width-1:0] i_wdata,
  input  logic             i_pop,
  output logic [width-1:0] o_rdata,
  output logic             o_full,
  output logic             o_empty,
  output logic [aw:0]      o_level
);

  logic [width-1:0] r_mem [depth];
  logic [aw-1:0]    r_wr_ptr;
  logic [aw-1:0]    r_rd_ptr;
  logic [aw:0]      r_level;
  logic             w_do_pop;
  logic             w_do_push;

  assign o_empty   = (r_level == '0);
  assign o_full    = (r_level == (aw+1)'(depth));
  assign w_do_pop  = i_pop && !o_empty;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign w_do_push = i_push && (!o_full || w_do_pop);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

  // NOTE: storage is deliberately not reset; the top masks the head while the
  // FIFO is empty, so stale contents are never visible.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_wdata;
  end

  assign o_rdata = r_mem[r_rd_ptr];
  assign o_level = r_level;

endmodule

// File: rtl/uart_rx_os.sv
// Oversampling UART receiver with run-time divisor, error/break flags and FIFO.
// Define UART_RX_MAJORITY_EN for a 3-sample majority vote per bit.
module uart_rx_os
  import uart_pkg::*;
#(
  parameter int data_bits   = 8,
  parameter int parity_type = 0,
  parameter int stop_bits   = 1,
  parameter int fifo_depth  = 8,
  parameter int div_width   = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        rx,
  input  logic [div_width-1:0]        baud_div,
  output logic [data_bits-1:0]        rx_data_out,
  output logic                        parity_err,
  output logic                        frame_err,
  output logic                        rx_data_vld,
  input  logic                        rx_data_rdy,
  output logic                        overrun,
  output logic                        break_det,
  output logic [$clog2(fifo_depth):0] fifo_level
);

  localparam int ew = data_bits + 2;

  rx_state_e             r_state, w_next;
  logic                  r_sync1, r_sync2, r_prev;
  logic [div_width-1:0]  r_baud_div, r_div_cnt;
  logic [3:0]            r_os_cnt, r_bit_cnt;
  logic [data_bits-1:0]  r_shift;
  logic                  r_par_bit, r_frm_err, r_stop_idx;
  logic                  r_overrun, r_break;
  logic                  w_fall, w_start, w_tick, w_dec_tick, w_bit_end, w_bit;
  logic                  w_stop_dec, w_last_stop, w_break, w_done, w_par_err;
  logic                  w_full, w_empty, w_pop;
  logic [ew-1:0]         w_head, w_head_vis;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_prev  <= 1'b1;
    end else begin
      r_sync1 <= rx;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
    end
  end

  // A held-low line never produces another fall, so after a break the FSM
  // naturally waits in IDLE until the line has gone high again.
  assign w_fall  = r_prev & ~r_sync2;
  assign w_start = (r_state == ST_IDLE) && w_fall;
  assign w_tick  = (r_div_cnt == r_baud_div);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_baud_div <= '0;
      r_div_cnt  <= '0;
      r_os_cnt   <= '0;
    end else if (r_state == ST_IDLE) begin
      r_baud_div <= baud_div;
      r_div_cnt  <= '0;
      r_os_cnt   <= '0;
    end else if (w_tick) begin
      r_div_cnt <= '0;
      r_os_cnt  <= r_os_cnt + 4'd1;
    end else begin
      r_div_cnt <= r_div_cnt + 1'b1;
    end
  end

`ifdef UART_RX_MAJORITY_EN
  logic r_s_early, r_s_mid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s_early <= 1'b1;
      r_s_mid   <= 1'b1;
    end else if (w_tick) begin
      if (r_os_cnt == SAMPLE_EARLY) r_s_early <= r_sync2;
      if (r_os_cnt == SAMPLE_MID)   r_s_mid   <= r_sync2;
    end
  end

  assign w_dec_tick = w_tick && (r_os_cnt == SAMPLE_LATE);
  assign w_bit      = (r_s_early & r_s_mid) | (r_s_early & r_sync2) | (r_s_mid & r_sync2);
`else
  assign w_dec_tick = w_tick && (r_os_cnt == SAMPLE_MID);
  assign w_bit      = r_sync2;
`endif

  assign w_bit_end   = w_tick && (r_os_cnt == OS_LAST);
  assign w_stop_dec  = (r_state == ST_STOP) && w_dec_tick;
  assign w_last_stop = (stop_bits == 1) || r_stop_idx;
  assign w_break     = w_stop_dec && !r_stop_idx && !w_bit && (r_shift == '0) &&
                       ((parity_type == PAR_NONE) || !r_par_bit);
  assign w_done      = w_stop_dec && w_last_stop && !w_break;
  assign w_par_err   = (parity_type == PAR_ODD)  ? (r_par_bit == ^r_shift)  :
                       (parity_type == PAR_EVEN) ? (r_par_bit == ~^r_shift) : 1'b0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  // NOTE: the next-state value is defaulted before the case so every path
  // assigns it and no latch is inferred.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:   if (w_fall) w_next = ST_START;
      ST_START: begin
        if (w_dec_tick && w_bit) w_next = ST_IDLE;
        else if (w_bit_end)      w_next = ST_DATA;
      end
      ST_DATA: begin
        if (w_bit_end && (r_bit_cnt == 4'(data_bits)))
          w_next = (parity_type != PAR_NONE) ? ST_PARITY : ST_STOP;
      end
      ST_PARITY: if (w_bit_end) w_next = ST_STOP;
      ST_STOP:   if (w_break || w_done) w_next = ST_IDLE;
      default:   w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_shift    <= '0;
      r_bit_cnt  <= '0;
      r_par_bit  <= 1'b0;
      r_frm_err  <= 1'b0;
      r_stop_idx <= 1'b0;
      r_overrun  <= 1'b0;
      r_break    <= 1'b0;
    end else begin
      r_overrun <= w_done && w_full && !w_pop;
      r_break   <= w_break;
      if (w_start) begin
        r_shift    <= '0;
        r_bit_cnt  <= '0;
        r_par_bit  <= 1'b0;
        r_frm_err  <= 1'b0;
        r_stop_idx <= 1'b0;
      end else if (w_dec_tick) begin
        case (r_state)
          ST_DATA: begin
            r_shift   <= {w_bit, r_shift[data_bits-1:1]};
            r_bit_cnt <= r_bit_cnt + 4'd1;
          end
          ST_PARITY: r_par_bit <= w_bit;
          ST_STOP:   if (!w_bit) r_frm_err <= 1'b1;
          default:   ;
        endcase
      end else if (w_bit_end && (r_state == ST_STOP)) begin
        r_stop_idx <= 1'b1;
      end
    end
  end

  assign w_pop = rx_data_vld && rx_data_rdy;

  uart_rx_fifo #(
    .width (ew),
    .depth (fifo_depth)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_done),
    .i_wdata ({r_frm_err | ~w_bit, w_par_err, r_shift}),
    .i_pop   (w_pop),
    .o_rdata (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_level (fifo_level)
  );

  assign w_head_vis  = w_empty ? '0 : w_head;
  assign rx_data_out = w_head_vis[data_bits-1:0];
  assign parity_err  = w_head_vis[data_bits];
  assign frame_err   = w_head_vis[data_bits+1];
  assign rx_data_vld = !w_empty;
  assign overrun     = r_overrun;
  assign break_det   = r_break;

endmodule

// File: tb/tb_uart_rx_os.sv
// Self-checking bench for uart_rx_os: 8 data bits, even parity, 1 stop bit.
module tb_uart_rx_os;

  localparam int BD = 1;
`ifdef UART_RX_MAJORITY_EN
  localparam bit MAJ = 1'b1;
`else
  localparam bit MAJ = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rx  = 1'b1;
  logic        rdy = 1'b0;
  logic [15:0] baud_div = 16'(BD);
  logic [7:0]  rx_data_out;
  logic        parity_err, frame_err, rx_data_vld, overrun, break_det;
  logic [3:0]  fifo_level;

  int errors = 0;
  int checks = 0;
  int brk_cnt = 0;
  int ovr_cnt = 0;
  int bit_clks = 16 * (BD + 1);
  logic [9:0] exp_q[$];

  uart_rx_os #(
    .data_bits(8), .parity_type(2), .stop_bits(1), .fifo_depth(8), .div_width(16)
  ) dut (
    .clk(clk), .rst(rst), .rx(rx), .baud_div(baud_div),
    .rx_data_out(rx_data_out), .parity_err(parity_err), .frame_err(frame_err),
    .rx_data_vld(rx_data_vld), .rx_data_rdy(rdy), .overrun(overrun),
    .break_det(break_det), .fifo_level(fifo_level)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (break_det) brk_cnt++;
    if (overrun)   ovr_cnt++;
  end

  // Reference: head entry {frame_err, parity_err, data} and break classification.
  function automatic logic [9:0] model_entry(input logic [7:0] d, input logic pbit,
                                             input logic stop);
    logic odd_total;
    odd_total = (($countones(d) + int'(pbit)) % 2) != 0;
    return {~stop, odd_total, d};
  endfunction

  function automatic bit model_break(input logic [7:0] d, input logic pbit, input logic stop);
    return (d == 8'h00) && !pbit && !stop;
  endfunction

  task automatic idle_clks(input int n);
    rx = 1'b1;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send_frame(input logic [7:0] d, input logic pbit, input logic stop,
                            input int spike_slot, input int spike_off);
    logic [10:0] bits;
    bits = {stop, pbit, d, 1'b0};
    for (int s = 0; s < 11; s++) begin
      for (int c = 0; c < bit_clks; c++) begin
        rx = (s == spike_slot && c >= spike_off && c < spike_off + 2) ? 1'b0 : bits[s];
        @(posedge clk); #1;
      end
    end
    rx = 1'b1;
  endtask

  task automatic pop_one();
    rdy = 1'b1;
    @(posedge clk); #1;
    rdy = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({rx_data_vld, fifo_level} !== 5'd0) begin
      errors++; $display("FAIL reset_vld_level: got %b want 00000", {rx_data_vld, fifo_level});
    end
    checks++;
    if ({rx_data_out, parity_err, frame_err, overrun, break_det} !== 12'd0) begin
      errors++;
      $display("FAIL reset_outputs: got %h want 000",
               {rx_data_out, parity_err, frame_err, overrun, break_det});
    end
    rst = 1'b0;
    idle_clks(40);
  endtask

  task automatic test_basic();
    int n;
    int exp_cyc;
    exp_cyc = MAJ ? 343 : 341;
    n = 0;
    fork
      send_frame(8'hA5, 1'b0, 1'b1, -1, 0);
      begin
        while (rx_data_vld !== 1'b1 && n < 400) begin @(posedge clk); #1; n++; end
      end
    join
    checks++;
    if (n != exp_cyc) begin
      errors++; $display("FAIL basic_vld_latency: got %0d cycles want %0d", n, exp_cyc);
    end
    checks++;
    if ({frame_err, parity_err, rx_data_out, fifo_level} !== {10'h0A5, 4'd1}) begin
      errors++;
      $display("FAIL basic_entry: got %h lvl %0d want 0a5 lvl 1",
               {frame_err, parity_err, rx_data_out}, fifo_level);
    end
    pop_one();
    checks++;
    if ({rx_data_vld, fifo_level} !== 5'd0) begin
      errors++; $display("FAIL basic_pop: got %b want 00000", {rx_data_vld, fifo_level});
    end
  endtask

  task automatic test_errors();
    send_frame(8'hA5, 1'b1, 1'b1, -1, 0);
    send_frame(8'h3C, 1'b0, 1'b0, -1, 0);
    idle_clks(bit_clks);
    checks++;
    if (fifo_level !== 4'd2) begin
      errors++; $display("FAIL err_level: got %0d want 2", fifo_level);
    end
    checks++;
    if ({frame_err, parity_err, rx_data_out} !== model_entry(8'hA5, 1'b1, 1'b1)) begin
      errors++; $display("FAIL parity_err_entry: got %h want %h",
                         {frame_err, parity_err, rx_data_out}, model_entry(8'hA5, 1'b1, 1'b1));
    end
    pop_one();
    checks++;
    if ({frame_err, parity_err, rx_data_out} !== model_entry(8'h3C, 1'b0, 1'b0)) begin
      errors++; $display("FAIL frame_err_entry: got %h want %h",
                         {frame_err, parity_err, rx_data_out}, model_entry(8'h3C, 1'b0, 1'b0));
    end
    pop_one();
  endtask

  task automatic test_false_start();
    int b0, o0;
    b0 = brk_cnt; o0 = ovr_cnt;
    rx = 1'b0;
    repeat (8) begin @(posedge clk); #1; end
    idle_clks(12 * bit_clks);
    checks++;
    if ({rx_data_vld, fifo_level} !== 5'd0 || brk_cnt != b0 || ovr_cnt != o0) begin
      errors++;
      $display("FAIL false_start: vld %b lvl %0d brk %0d ovr %0d want all 0",
               rx_data_vld, fifo_level, brk_cnt - b0, ovr_cnt - o0);
    end
    send_frame(8'h5A, 1'b0, 1'b1, -1, 0);
    idle_clks(bit_clks);
    checks++;
    if ({frame_err, parity_err, rx_data_out, fifo_level} !== {10'h05A, 4'd1}) begin
      errors++; $display("FAIL after_false_start: got %h lvl %0d want 05a lvl 1",
                         {frame_err, parity_err, rx_data_out}, fifo_level);
    end
    pop_one();
  endtask

  task automatic test_overrun();
    int o0;
    o0 = ovr_cnt;
    rdy = 1'b0;
    for (int i = 1; i <= 9; i++) send_frame(8'(i), ^(8'(i)), 1'b1, -1, 0);
    idle_clks(bit_clks);
    checks++;
    if (fifo_level !== 4'd8 || ovr_cnt - o0 != 1) begin
      errors++; $display("FAIL overrun: lvl %0d pulses %0d want lvl 8 pulses 1",
                         fifo_level, ovr_cnt - o0);
    end
    for (int i = 1; i <= 8; i++) begin
      checks++;
      if ({rx_data_vld, frame_err, parity_err, rx_data_out} !== {3'b100, 8'(i)}) begin
        errors++; $display("FAIL drain[%0d]: got %h want %h", i,
                           {rx_data_vld, frame_err, parity_err, rx_data_out}, {3'b100, 8'(i)});
      end
      pop_one();
    end
    checks++;
    if (fifo_level !== 4'd0) begin
      errors++; $display("FAIL drain_level: got %0d want 0", fifo_level);
    end
  endtask

  task automatic test_break();
    int b0;
    b0 = brk_cnt;
    rx = 1'b0;
    repeat (12 * bit_clks) begin @(posedge clk); #1; end
    idle_clks(2 * bit_clks);
    checks++;
    if (brk_cnt - b0 != 1 || fifo_level !== 4'd0) begin
      errors++; $display("FAIL break: pulses %0d lvl %0d want 1 and 0", brk_cnt - b0, fifo_level);
    end
    send_frame(8'h55, 1'b0, 1'b1, -1, 0);
    idle_clks(bit_clks);
    checks++;
    if ({frame_err, parity_err, rx_data_out, fifo_level} !== {10'h055, 4'd1}) begin
      errors++; $display("FAIL after_break: got %h lvl %0d want 055 lvl 1",
                         {frame_err, parity_err, rx_data_out}, fifo_level);
    end
    pop_one();
  endtask

  task automatic test_spike();
    logic [7:0] exp_d;
    exp_d = MAJ ? 8'hFF : 8'hF7;
    // Spike covers only the mid sample point of data bit 3 (frame slot 4).
    send_frame(8'hFF, 1'b0, 1'b1, 4, (BD + 1) * 9);
    idle_clks(bit_clks);
    checks++;
    if ({frame_err, parity_err, rx_data_out} !== model_entry(exp_d, 1'b0, 1'b1)) begin
      errors++; $display("FAIL spike: got %h want %h",
                         {frame_err, parity_err, rx_data_out}, model_entry(exp_d, 1'b0, 1'b1));
    end
    pop_one();
  endtask

  task automatic test_div0();
    baud_div = 16'd0;
    bit_clks = 16;
    idle_clks(4);
    send_frame(8'hC3, 1'b0, 1'b1, -1, 0);
    idle_clks(bit_clks);
    checks++;
    if ({frame_err, parity_err, rx_data_out, fifo_level} !== {10'h0C3, 4'd1}) begin
      errors++; $display("FAIL div0: got %h lvl %0d want 0c3 lvl 1",
                         {frame_err, parity_err, rx_data_out}, fifo_level);
    end
    pop_one();
    baud_div = 16'(BD);
    bit_clks = 16 * (BD + 1);
    idle_clks(4);
  endtask

  task automatic test_back_to_back();
    for (int batch = 0; batch < 4; batch++) begin
      int nb, exp_brk, b0;
      nb = $urandom_range(1, 6);
      exp_brk = 0;
      b0 = brk_cnt;
      exp_q.delete();
      for (int k = 0; k < nb; k++) begin
        logic [7:0] d;
        logic pbit, stop;
        d    = ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom);
        pbit = (^d) ^ ($urandom_range(0, 3) == 0);
        stop = ($urandom_range(0, 3) != 0);
        if (model_break(d, pbit, stop)) exp_brk++;
        else exp_q.push_back(model_entry(d, pbit, stop));
        send_frame(d, pbit, stop, -1, 0);
        idle_clks(bit_clks);
      end
      checks++;
      if (int'(fifo_level) != exp_q.size() || brk_cnt - b0 != exp_brk) begin
        errors++; $display("FAIL b2b_level[%0d]: lvl %0d brk %0d want %0d brk %0d", batch,
                           fifo_level, brk_cnt - b0, exp_q.size(), exp_brk);
      end
      while (exp_q.size() > 0) begin
        logic [9:0] e;
        e = exp_q.pop_front();
        checks++;
        if ({frame_err, parity_err, rx_data_out} !== e) begin
          errors++; $display("FAIL b2b_entry[%0d]: got %h want %h", batch,
                             {frame_err, parity_err, rx_data_out}, e);
        end
        pop_one();
      end
    end
  endtask

  task automatic test_reset_mid();
    int b0;
    send_frame(8'h11, 1'b0, 1'b1, -1, 0);
    idle_clks(bit_clks);
    b0 = brk_cnt;
    rx = 1'b0;
    repeat (100) begin @(posedge clk); #1; end
    rx  = 1'b1;
    rst = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    rst = 1'b0;
    idle_clks(2 * bit_clks);
    checks++;
    if ({rx_data_vld, fifo_level} !== 5'd0 || brk_cnt != b0) begin
      errors++; $display("FAIL reset_mid: vld %b lvl %0d brk %0d want 0",
                         rx_data_vld, fifo_level, brk_cnt - b0);
    end
    send_frame(8'h81, 1'b0, 1'b1, -1, 0);
    idle_clks(bit_clks);
    checks++;
    if ({frame_err, parity_err, rx_data_out, fifo_level} !== {10'h081, 4'd1}) begin
      errors++; $display("FAIL after_reset_mid: got %h lvl %0d want 081 lvl 1",
                         {frame_err, parity_err, rx_data_out}, fifo_level);
    end
    pop_one();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_basic();
    test_errors();
    test_false_start();
    test_overrun();
    test_break();
    test_spike();
    test_div0();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_rx_os.md
# uart_rx_os

Oversampling UART receiver with a run-time baud divisor, majority-vote bit sampling, framing/parity/break detection and an output FIFO with valid/ready handshake. It sits between the asynchronous `rx` pin and the host-side register/DMA logic. It is the parametrised successor of the single-sample fixed-baud receiver.

## Interface

Parameters:
- `data_bits`, 8: data bits per frame, range 5–9.
- `parity_type`, 0: 0 = none, 1 = odd, 2 = even.
- `stop_bits`, 1: range 1–2.
- `fifo_depth`, 8: FIFO entries; power of 2, ≥ 2.
- `div_width`, 16: width of `baud_div`.

Ports:
- `clk` in 1: the single clock.
- `rst` in 1: reset, asynchronous, active-high.
- `rx` in 1: serial line, asynchronous to `clk`, idles high.
- `baud_div` in `div_width`: clocks per oversample tick minus 1; bit period = 16·(`baud_div`+1) clocks.
- `rx_data_out` out `data_bits`: data field of the FIFO head entry.
- `parity_err` out 1: parity flag of the head entry.
- `frame_err` out 1: stop-bit error flag of the head entry.
- `rx_data_vld` out 1: FIFO not empty.
- `rx_data_rdy` in 1: consumer accepts the head entry.
- `overrun` out 1: 1-cycle pulse when a completed frame is dropped because the FIFO is full.
- `break_det` out 1: 1-cycle pulse on a detected break.
- `fifo_level` out `$clog2(fifo_depth)+1`: current entry count.

## Operation

- **Input path.** `rx` passes through a 2-flop synchroniser, reset to 1. Start detection uses a falling edge of the synchronised line, taken from the previous synchronised value.
- **Tick generator.** A counter runs 0..`baud_div` and emits a tick at `baud_div`.
  - The counter and the oversample counter `os_cnt` (0..15) clear on start detection.
  - `baud_div` is latched only in IDLE; changes mid-frame take effect on the next frame.
- **Bit sampling.** The line is sampled at ticks with `os_cnt` = 7, 8 and 9. The bit value is the majority of the three, decided at `os_cnt` = 9.
- **FSM states:** IDLE, START, DATA, PARITY, STOP.
  - **IDLE → START** on a falling edge.
  - **START:** a decided value of 1 at `os_cnt` = 9 is a false start and returns to IDLE. A value of 0 continues to `os_cnt` = 15 and then enters DATA.
  - **DATA:** captures bits LSB first into a shift register. After `data_bits` bits it goes to PARITY if `parity_type` ≠ 0, otherwise to STOP.
  - **PARITY:**
    - odd: `parity_err` = (parity bit == XOR of data).
    - even: `parity_err` = (parity bit == XNOR of data).
    - With `parity_type` = 0, `parity_err` is always 0.
  - **STOP:** each stop bit is checked at `os_cnt` = 9; any 0 sets `frame_err`. When the last stop bit is decided, the frame completes and the FSM returns to IDLE immediately, leaving half a bit of margin for resynchronisation.
- **Break.** A frame whose data, parity (if present) and first stop bit are all 0 is a break.
  - `break_det` pulses once.
  - Nothing is pushed.
  - The FSM stays in IDLE until the line returns high; a new start still requires a falling edge.
- **FIFO.**
  - Each entry is {`frame_err`, `parity_err`, data}, pushed on frame completion.
  - Pop happens on `rx_data_vld` && `rx_data_rdy`.
  - Push when full drops the new frame and pulses `overrun`; stored entries are unchanged.
  - Simultaneous push and pop when full: both happen, no overrun.
  - Simultaneous push and pop when empty: only the push happens; `rx_data_vld` is 0 in that cycle.
  - Read and write pointers wrap modulo `fifo_depth`.
  - Head outputs are show-ahead. Their value when empty is unspecified but stable.

## Timing

- **Reset values.**
  - `rx_data_vld`, `parity_err`, `frame_err`, `overrun`, `break_det`: 0.
  - `fifo_level`: 0; `rx_data_out`: 0.
  - FSM in IDLE; synchroniser at 1.
- **Reset mid-frame** discards the frame in progress and all FIFO contents.
- **Latency.**
  - `rx` edge to synchronised edge: 2 clocks.
  - Push happens in the cycle of the last stop-bit decision tick.
  - `rx_data_vld` and `fifo_level` update on the following clock edge.
  - Pop updates the head and level 1 clock after the handshake.
- **`baud_div` = 0** is legal: one tick per clock, bit period 16 clocks.

## Configuration

- `UART_RX_MAJORITY_EN` defined: 3-sample majority vote at `os_cnt` 7/8/9.
- Undefined: a single sample at `os_cnt` = 8 decides the bit. The sample registers are removed, and the decision point moves to `os_cnt` = 8.

## Structure

- **Package `uart_pkg`:**
  - FSM state enum.
  - `PAR_NONE`/`PAR_ODD`/`PAR_EVEN` constants.
  - `OVERSAMPLE` = 16.
  - Sample-point constants 7/8/9.
- **Sub-module `uart_rx_fifo`:** register-based synchronous FIFO with push, pop, full, empty and level. It is instantiated once for the `data_bits`+2-wide entry.

## Test plan

All scenarios use `baud_div` = 1 (32 clocks per bit), `data_bits` = 8, 1 stop bit, and even parity unless stated otherwise.

- Send 0xA5 with parity bit 0 and stop 1 → one entry: 0xA5, `parity_err` 0, `frame_err` 0. `rx_data_vld` rises 1 clock after push, and `fifo_level` returns to 0 after the pop with `rx_data_rdy`.
- Send 0xA5 with parity bit 1 → entry 0xA5 with `parity_err` 1. Send 0x3C with stop bit 0 → entry 0x3C with `frame_err` 1.
- Drive `rx` low for 8 clocks, then high → no entry, no flags, FSM back in IDLE.
- Hold `rx_data_rdy` = 0 and send 9 frames 0x01..0x09 with `fifo_depth` = 8 → `fifo_level` 8 and one `overrun` pulse. Draining yields 0x01..0x08 in order.
- Hold `rx` low for 12 bit times, then high → one `break_det` pulse and no entry. A following frame 0x55 is received correctly.
- With `UART_RX_MAJORITY_EN` defined, apply a 2-clock low spike at `os_cnt` 8 of data bit 3 of 0xFF → 0xFF is received. With the macro undefined, the same stimulus gives 0xF7.
